hdmi_sync_supervisor: RTL and testbench

Sequences and supervises the three per-colour HDMI pixel-sync engines of the receive bit-sync stage. It holds each engine in reset and releases it, waits for lock, and qualifies the lock over a stability window. Channels that fail to lock or that later lose lock are re-acquired individually. It reports a single qualified-lock flag plus a 32-bit status word for the control bus, and sits between the control bus and the bit-sync datapath in the pixel clock domain.

---
 rtl/hdmi_pkg.sv | 38 +++
 rtl/hdmi_chan_monitor.sv | 52 +++++
 rtl/hdmi_sync_supervisor.sv | 167 ++++++++++++++++
 tb/tb_hdmi_sync_supervisor.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared types and field layout for the HDMI bit-sync supervisor.
// Holds the FSM state encoding, sync-word fields and status-word packing.
package hdmi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_QUALIFY = 3'd3,
        ST_LOCKED  = 3'd4
    } state_t;

    localparam int SYNC_W        = 5;
    localparam int SYNC_LOCK_BIT = 4;
    localparam int SYNC_SLIP_LSB = 0;
    localparam int SYNC_SLIP_W   = 4;

    localparam int STAT_STATE_LSB = 29;
    localparam int STAT_RETRY_LSB = 16;
    localparam int STAT_CRST_LSB  = 8;
    localparam int STAT_LOCK_LSB  = 0;

    function automatic logic [31:0] pack_status(
        input logic [2:0] st,
        input logic [7:0] retries,
        input logic [2:0] chan_reset,
        input logic [2:0] lock_now
    );
        logic [31:0] w_word;
        w_word = '0;
        w_word[STAT_STATE_LSB +: 3] = st;
        w_word[STAT_RETRY_LSB +: 8] = retries;
        w_word[STAT_CRST_LSB  +: 3] = chan_reset;
        w_word[STAT_LOCK_LSB  +: 3] = lock_now;
        return w_word;
    endfunction

endpackage

// File: rtl/hdmi_chan_monitor.sv
// Per-channel monitor: registers the engine sync word, compares slip against a snapshot,
// and counts consecutive unlocked cycles while the supervisor is LOCKED. One cycle input latency.
module hdmi_chan_monitor
    import hdmi_pkg::*;
#(
    parameter int DROP_CYCLES = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [SYNC_W-1:0] i_sync,
    input  logic              i_snap_load,
    input  logic              i_drop_en,
    output logic              o_lock,
    output logic              o_slip_changed,
    output logic              o_lost
);
    localparam int DW = $clog2(DROP_CYCLES + 1);
    localparam logic [DW-1:0] DROP_LAST = DW'(DROP_CYCLES - 1);
    localparam logic [DW-1:0] DROP_MAX  = DW'(DROP_CYCLES);

    logic [SYNC_W-1:0]      r_sync;
    logic [SYNC_SLIP_W-1:0] r_snap;
    logic [DW-1:0]          r_drop;
    logic [SYNC_SLIP_W-1:0] w_slip;

    assign w_slip = r_sync[SYNC_SLIP_LSB +: SYNC_SLIP_W];
    assign o_lock = r_sync[SYNC_LOCK_BIT];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= '0;
            r_snap <= '0;
            r_drop <= '0;
        end else begin
            r_sync <= i_sync;
            if (i_snap_load) begin
                r_snap <= w_slip;
            end
            if (!i_drop_en || o_lock) begin
                r_drop <= '0;
            end else if (r_drop != DROP_MAX) begin
                r_drop <= r_drop + 1'b1;
            end
        end
    end

    // A slip move only matters on a channel that still claims lock.
    assign o_slip_changed = o_lock && (w_slip != r_snap);
    // Fires on the cycle that completes DROP_CYCLES consecutive unlocked samples.
    assign o_lost         = i_drop_en && !o_lock && (r_drop >= DROP_LAST);

endmodule

// File: rtl/hdmi_sync_supervisor.sv
// Resets, acquires and qualifies the three per-colour pixel-sync engines, re-acquiring failed channels.
// All outputs registered; sync inputs are registered once before any decision.
module hdmi_sync_supervisor
    import hdmi_pkg::*;
#(
    parameter int RESET_CYCLES  = 16,
    parameter int TIMEOUT_LG    = 20,
    parameter int STABLE_CYCLES = 1024,
    parameter int DROP_CYCLES   = 8
) (
    input  logic        i_pix_clk,
    input  logic        i_reset_n,
    input  logic        i_enable,
    input  logic        i_force_resync,
    input  logic [4:0]  i_sync_r,
    input  logic [4:0]  i_sync_g,
    input  logic [4:0]  i_sync_b,
    output logic [2:0]  o_chan_reset,
    output logic        o_locked,
    output logic [31:0] o_status
);
    localparam int RCW = $clog2(RESET_CYCLES + 1);
    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam logic [RCW-1:0] RC_LAST = RCW'(RESET_CYCLES - 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(STABLE_CYCLES - 1);

    state_t                r_state, w_state_nxt;
    logic [2:0]            r_chan_reset, w_chan_reset_nxt;
    logic                  r_locked, w_locked_nxt;
    logic [7:0]            r_retries, w_retries_nxt, w_retries_inc;
    logic [RCW-1:0]        r_rcnt, w_rcnt_nxt;
    logic [TIMEOUT_LG-1:0] r_tcnt, w_tcnt_nxt;
    logic [SCW-1:0]        r_scnt, w_scnt_nxt;
    logic                  w_snap_load, w_drop_en, w_all_lock;
    logic [SYNC_W-1:0]     w_sync [3];
    logic [2:0]            w_lock, w_slip_chg, w_lost;

    assign w_sync[2] = i_sync_r;
    assign w_sync[1] = i_sync_g;
    assign w_sync[0] = i_sync_b;
    assign w_drop_en = (r_state == ST_LOCKED);

    for (genvar c = 0; c < 3; c++) begin : g_chan
        hdmi_chan_monitor #(.DROP_CYCLES(DROP_CYCLES)) u_mon (
            .i_clk          (i_pix_clk),
            .i_reset_n      (i_reset_n),
            .i_sync         (w_sync[c]),
            .i_snap_load    (w_snap_load),
            .i_drop_en      (w_drop_en),
            .o_lock         (w_lock[c]),
            .o_slip_changed (w_slip_chg[c]),
            .o_lost         (w_lost[c])
        );
    end

    assign w_all_lock    = &w_lock;
    assign w_retries_inc = (r_retries == 8'hFF) ? r_retries : r_retries + 8'd1;

    always_comb begin
        w_state_nxt      = r_state;
        w_chan_reset_nxt = r_chan_reset;
        w_locked_nxt     = r_locked;
        w_retries_nxt    = r_retries;
        w_rcnt_nxt       = r_rcnt;
        w_tcnt_nxt       = r_tcnt;
        w_scnt_nxt       = r_scnt;
        w_snap_load      = 1'b0;
        if (!i_enable) begin
            w_state_nxt      = ST_IDLE;
            w_chan_reset_nxt = 3'b111;
            w_locked_nxt     = 1'b0;
        end else if (i_force_resync) begin
            w_state_nxt      = ST_RESET;
            w_chan_reset_nxt = 3'b111;
            w_locked_nxt     = 1'b0;
            w_rcnt_nxt       = '0;
            if (r_state == ST_IDLE) begin
                w_retries_nxt = 8'd0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt      = ST_RESET;
                    w_chan_reset_nxt = 3'b111;
                    w_rcnt_nxt       = '0;
                    w_retries_nxt    = 8'd0;
                end
                ST_RESET: begin
                    if (r_rcnt == RC_LAST) begin
                        w_state_nxt      = ST_ACQUIRE;
                        w_chan_reset_nxt = 3'b000;
                        w_tcnt_nxt       = '0;
                    end else begin
                        w_rcnt_nxt = r_rcnt + 1'b1;
                    end
                end
                ST_ACQUIRE: begin
                    if (w_all_lock) begin
                        w_state_nxt = ST_QUALIFY;
                        w_scnt_nxt  = '0;
                        w_snap_load = 1'b1;
                    end else if (&r_tcnt) begin
                        // Only the channels that never locked go back into reset.
                        w_state_nxt      = ST_RESET;
                        w_chan_reset_nxt = ~w_lock;
                        w_retries_nxt    = w_retries_inc;
                        w_rcnt_nxt       = '0;
                    end else begin
                        w_tcnt_nxt = r_tcnt + 1'b1;
                    end
                end
                ST_QUALIFY: begin
                    if (!w_all_lock) begin
                        w_state_nxt = ST_ACQUIRE;
                    end else if (|w_slip_chg) begin
                        w_snap_load = 1'b1;
                        w_scnt_nxt  = '0;
                    end else if (r_scnt == SC_LAST) begin
                        w_state_nxt  = ST_LOCKED;
                        w_locked_nxt = 1'b1;
                    end else begin
                        w_scnt_nxt = r_scnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (|(w_lost | w_slip_chg)) begin
                        w_state_nxt      = ST_RESET;
                        w_chan_reset_nxt = w_lost | w_slip_chg;
                        w_locked_nxt     = 1'b0;
                        w_retries_nxt    = w_retries_inc;
                        w_rcnt_nxt       = '0;
                    end
                end
                default: begin
                    w_state_nxt      = ST_IDLE;
                    w_chan_reset_nxt = 3'b111;
                    w_locked_nxt     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_chan_reset <= 3'b111;
            r_locked     <= 1'b0;
            r_retries    <= 8'd0;
            r_rcnt       <= '0;
            r_tcnt       <= '0;
            r_scnt       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_chan_reset <= w_chan_reset_nxt;
            r_locked     <= w_locked_nxt;
            r_retries    <= w_retries_nxt;
            r_rcnt       <= w_rcnt_nxt;
            r_tcnt       <= w_tcnt_nxt;
            r_scnt       <= w_scnt_nxt;
        end
    end

    assign o_chan_reset = r_chan_reset;
    assign o_locked     = r_locked;
    assign o_status     = pack_status(r_state, r_retries, r_chan_reset, w_lock);

endmodule

// File: tb/tb_hdmi_sync_supervisor.sv
// Directed scenarios plus randomized lock/slip noise, every cycle compared against a behavioural model.
module tb_hdmi_sync_supervisor;
    localparam int RC  = 16;
    localparam int TLG = 8;
    localparam int SC  = 1024;
    localparam int DC  = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        frc   = 1'b0;
    logic [4:0]  s_r   = 5'd0;
    logic [4:0]  s_g   = 5'd0;
    logic [4:0]  s_b   = 5'd0;
    logic [2:0]  chan_rst;
    logic        locked;
    logic [31:0] status;

    int n_vec = 0;
    int n_err = 0;

    hdmi_sync_supervisor #(
        .RESET_CYCLES(RC), .TIMEOUT_LG(TLG), .STABLE_CYCLES(SC), .DROP_CYCLES(DC)
    ) dut (
        .i_pix_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_force_resync(frc),
        .i_sync_r(s_r), .i_sync_g(s_g), .i_sync_b(s_b),
        .o_chan_reset(chan_rst), .o_locked(locked), .o_status(status)
    );

    always #5 clk = ~clk;

    // Reference model: states 0 idle, 1 reset, 2 acquire, 3 qualify, 4 locked.
    int         m_st, m_ret, m_rc, m_tc, m_sc;
    logic [2:0] m_mask;
    logic       m_lk;
    logic [4:0] m_q [3];
    logic [3:0] m_snap [3];
    int         m_drop [3];

    task automatic model_reset();
        m_st = 0; m_ret = 0; m_rc = 0; m_tc = 0; m_sc = 0;
        m_mask = 3'b111; m_lk = 1'b0;
        for (int c = 0; c < 3; c++) begin
            m_q[c] = 5'd0; m_snap[c] = 4'd0; m_drop[c] = 0;
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [2:0] l;
        l = {m_q[2][4], m_q[1][4], m_q[0][4]};
        return {m_st[2:0], 5'h0, m_ret[7:0], 5'h0, m_mask, 5'h0, l};
    endfunction

    task automatic model_step();
        logic [4:0] in_s [3];
        logic [2:0] l, lost, chg;
        int         st;
        in_s[2] = s_r; in_s[1] = s_g; in_s[0] = s_b;
        l = {m_q[2][4], m_q[1][4], m_q[0][4]};
        lost = 3'b000; chg = 3'b000;
        st = m_st;
        for (int c = 0; c < 3; c++) begin
            if (st == 4 && !l[c] && m_drop[c] + 1 >= DC) lost[c] = 1'b1;
            if (l[c] && m_q[c][3:0] != m_snap[c]) chg[c] = 1'b1;
            m_drop[c] = (st == 4 && !l[c]) ? m_drop[c] + 1 : 0;
        end
        if (!en) begin
            m_st = 0; m_mask = 3'b111; m_lk = 1'b0;
        end else if (frc) begin
            if (st == 0) m_ret = 0;
            m_st = 1; m_mask = 3'b111; m_rc = 0; m_lk = 1'b0;
        end else begin
            case (st)
                0: begin m_st = 1; m_mask = 3'b111; m_rc = 0; m_ret = 0; end
                1: if (m_rc == RC - 1) begin m_st = 2; m_mask = 3'b000; m_tc = 0; end
                   else m_rc++;
                2: if (l == 3'b111) begin
                       m_st = 3; m_sc = 0;
                       for (int c = 0; c < 3; c++) m_snap[c] = m_q[c][3:0];
                   end else if (m_tc == (1 << TLG) - 1) begin
                       m_mask = ~l; m_ret = (m_ret < 255) ? m_ret + 1 : 255; m_st = 1; m_rc = 0;
                   end else m_tc++;
                3: if (l != 3'b111) m_st = 2;
                   else if (chg != 3'b000) begin
                       m_sc = 0;
                       for (int c = 0; c < 3; c++) m_snap[c] = m_q[c][3:0];
                   end else if (m_sc == SC - 1) begin m_st = 4; m_lk = 1'b1; end
                   else m_sc++;
                default: if ((lost | chg) != 3'b000) begin
                       m_mask = lost | chg; m_ret = (m_ret < 255) ? m_ret + 1 : 255;
                       m_st = 1; m_rc = 0; m_lk = 1'b0;
                   end
            endcase
        end
        for (int c = 0; c < 3; c++) m_q[c] = in_s[c];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("chan_reset", {29'd0, chan_rst}, {29'd0, m_mask});
        chk("locked", {31'd0, locked}, {31'd0, m_lk});
        chk("status", status, m_status());
    endtask

    task automatic wait_state(input logic [2:0] st, input int bound, output int n);
        n = 0;
        while (status[31:29] != st && n < bound) begin tick(); n++; end
        chk("wait_state", {29'd0, status[31:29]}, {29'd0, st});
    endtask

    task automatic wait_locked(input logic v, input int bound, output int n);
        n = 0;
        while (locked != v && n < bound) begin tick(); n++; end
        chk("wait_locked", {31'd0, locked}, {31'd0, v});
    endtask

    task automatic wait_crst(input logic [2:0] v, input int bound, output int n);
        n = 0;
        while (chan_rst != v && n < bound) begin tick(); n++; end
        chk("wait_crst", {29'd0, chan_rst}, {29'd0, v});
    endtask

    initial begin
        int n;
        int len;
        model_reset();
        #12;
        chk("rst_chan_reset", {29'd0, chan_rst}, 32'd7);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_status", status, 32'h0000_0700);

        // Bring-up: all channels lock 5 cycles after channel reset falls.
        s_r = {1'b0, 4'd1}; s_g = {1'b0, 4'd2}; s_b = {1'b0, 4'd3};
        en = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        wait_state(3'd1, 10, n);
        wait_crst(3'b000, 40, n);
        chk("s1_reset_len", n, 32'd16);
        repeat (4) tick();
        s_r[4] = 1'b1; s_g[4] = 1'b1; s_b[4] = 1'b1;
        wait_state(3'd3, 20, n);
        wait_locked(1'b1, 1100, n);
        chk("s1_qualify_len", n, 32'd1024);
        chk("s1_retries", {24'd0, status[23:16]}, 32'd0);

        // Short dropout tolerated, full DROP_CYCLES dropout re-acquires R only.
        s_r[4] = 1'b0;
        repeat (7) tick();
        s_r[4] = 1'b1;
        repeat (20) tick();
        chk("s2_hold_locked", {31'd0, locked}, 32'd1);
        s_r[4] = 1'b0;
        wait_crst(3'b100, 20, n);
        chk("s2_drop_edges", n, 32'd9);
        chk("s2_locked_fall", {31'd0, locked}, 32'd0);
        chk("s2_retries", {24'd0, status[23:16]}, 32'd1);
        s_r[4] = 1'b1;

        // Slip change on B mid-qualification restarts the stable count.
        wait_state(3'd3, 60, n);
        repeat (500) tick();
        s_b = {1'b1, 4'd4};
        wait_locked(1'b1, 1200, n);
        chk("s3_restart_len", n, 32'd1026);

        // Forced resync keeps retries; G then never locks and times out alone.
        frc = 1'b1; s_g[4] = 1'b0;
        tick();
        frc = 1'b0;
        chk("s4_force_crst", {29'd0, chan_rst}, 32'd7);
        chk("s4_force_locked", {31'd0, locked}, 32'd0);
        chk("s4_force_retries", {24'd0, status[23:16]}, 32'd1);
        wait_state(3'd2, 30, n);
        wait_crst(3'b010, 300, n);
        chk("s4_timeout_len", n, 32'd256);
        chk("s4_timeout_retries", {24'd0, status[23:16]}, 32'd2);
        chk("s4_timeout_state", {29'd0, status[31:29]}, 32'd1);
        wait_crst(3'b000, 30, n);
        chk("s4_g_reset_len", n, 32'd16);
        chk("s4_acquire_again", {29'd0, status[31:29]}, 32'd2);

        // Disable beats force.
        frc = 1'b1; en = 1'b0;
        tick();
        frc = 1'b0;
        chk("s5_idle_state", {29'd0, status[31:29]}, 32'd0);
        chk("s5_idle_crst", {29'd0, chan_rst}, 32'd7);
        repeat (3) tick();

        // Randomized quiet/noisy epochs.
        en = 1'b1;
        for (int ep = 0; ep < 8; ep++) begin
            len = (ep % 2 == 0) ? 1300 : 300;
            if (ep % 2 == 0) begin
                s_r = {1'b1, 4'($urandom)}; s_g = {1'b1, 4'($urandom)}; s_b = {1'b1, 4'($urandom)};
            end
            for (int i = 0; i < len; i++) begin
                if (ep % 2 == 1) begin
                    if ($urandom_range(0, 15) == 0) s_r[4] = ~s_r[4];
                    if ($urandom_range(0, 15) == 0) s_g[4] = ~s_g[4];
                    if ($urandom_range(0, 15) == 0) s_b[4] = ~s_b[4];
                    if ($urandom_range(0, 31) == 0) s_b[3:0] = 4'($urandom);
                    if ($urandom_range(0, 31) == 0) s_r[3:0] = 4'($urandom);
                    if ($urandom_range(0, 199) == 0) frc = 1'b1;
                    if ($urandom_range(0, 399) == 0) en = 1'b0;
                end
                tick();
                frc = 1'b0; en = 1'b1;
            end
        end

        // Asynchronous reset in the middle of qualification.
        s_r[4] = 1'b1; s_g[4] = 1'b1; s_b[4] = 1'b1;
        frc = 1'b1;
        tick();
        frc = 1'b0;
        wait_state(3'd3, 60, n);
        repeat (100) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("s7_async_crst", {29'd0, chan_rst}, 32'd7);
        chk("s7_async_locked", {31'd0, locked}, 32'd0);
        chk("s7_async_status", status, 32'h0000_0700);
        model_reset();
        en = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
